alu_rr_arbiter: RTL and testbench

Shares one 2-bit-opcode combinational ALU (add/sub/and/or, zero flag) among NREQ requesters. Each requester has its own valid/ready request channel. A round-robin arbiter picks one request per cycle and registers the result in a single-entry response stage with valid/ready backpressure. It sits between issue ports (lane groups, address generators) and the shared integer ALU.

---
 rtl/alu_rr_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_rr_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: one shared add/sub/and/or ALU with a zero flag, serving
// NREQ valid/ready requesters through a round-robin arbiter. Each accepted
// operation lands in a single-entry response register with valid/ready
// backpressure, so the block sustains one op per cycle with 1-cycle latency.
module alu_rr_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_opcode,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [WIDTH-1:0]        resp_y,
  output logic                    resp_zero
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Shared ALU; add/sub wrap modulo 2^WIDTH, no carry is exported.
  function automatic logic [WIDTH-1:0] alu_f(input logic [1:0]       op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = '0;
    endcase
    return y;
  endfunction

  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_resp_valid;
  logic [ID_W-1:0]  r_resp_id;
  logic [WIDTH-1:0] r_resp_y;
  logic             r_resp_zero;

  logic             w_grant_vld;
  logic [ID_W-1:0]  w_grant;
  logic             w_can_accept;
  logic             w_accept;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_y;
  logic [ID_W-1:0]  w_next_ptr;

  // Round-robin scan: first valid requester starting at r_rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_grant_vld && req_valid[idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = ID_W'(idx);
      end else begin
        w_grant_vld = w_grant_vld;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_op = 2'b00;
    w_a  = '0;
    w_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_op = req_opcode[2*i +: 2];
        w_a  = req_a[WIDTH*i +: WIDTH];
        w_b  = req_b[WIDTH*i +: WIDTH];
      end else begin
        w_op = w_op;
      end
    end
  end

  assign w_y          = alu_f(w_op, w_a, w_b);
  assign w_can_accept = !r_resp_valid || resp_ready;
  assign w_accept     = rst_n && w_can_accept && w_grant_vld;
  assign w_next_ptr   = (w_grant == ID_W'(NREQ - 1)) ? '0 : (w_grant + ID_W'(1));

  // Per-requester ready: one-hot on the grant, forced low while in reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rst_n && w_can_accept && w_grant_vld && (w_grant == ID_W'(i))) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Response register and round-robin pointer; pointer moves only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_y     <= '0;
      r_resp_zero  <= 1'b0;
      r_rr_ptr     <= '0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_id    <= w_grant;
      r_resp_y     <= w_y;
      r_resp_zero  <= (w_y == '0);
      r_rr_ptr     <= w_next_ptr;
    end else if (r_resp_valid && resp_ready) begin
      r_resp_valid <= 1'b0;
    end else begin
      r_resp_valid <= r_resp_valid;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_y     = r_resp_y;
  assign resp_zero  = r_resp_zero;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter (WIDTH=32, NREQ=4).
module tb_alu_rr_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_opcode;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [WIDTH-1:0]      resp_y;
  logic                  resp_zero;

  int n_checks;
  int n_errors;

  alu_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .resp_zero  (resp_zero)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_opcode[2*i +: 2]     = op;
    req_a[WIDTH*i +: WIDTH]  = a;
    req_b[WIDTH*i +: WIDTH]  = b;
  endtask

  task automatic check_resp(input string tag, input logic [1:0] id, input logic [31:0] y, input logic z);
    check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_id"},    {30'd0, resp_id},    {30'd0, id});
    check({tag, "_y"},     resp_y,              y);
    check({tag, "_zero"},  {31'd0, resp_zero},  {31'd0, z});
  endtask

  logic [1:0]  t2_op [4];
  logic [31:0] t2_a  [4];
  logic [31:0] t2_b  [4];
  logic [31:0] t2_y  [4];
  logic        t2_z  [4];

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    req_valid  = 4'b0000;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    t2_op[0] = 2'b01; t2_a[0] = 32'd7;          t2_b[0] = 32'd7;          t2_y[0] = 32'h0000_0000; t2_z[0] = 1'b1;
    t2_op[1] = 2'b01; t2_a[1] = 32'd0;          t2_b[1] = 32'd1;          t2_y[1] = 32'hFFFF_FFFF; t2_z[1] = 1'b0;
    t2_op[2] = 2'b10; t2_a[2] = 32'hF0F0_F0F0; t2_b[2] = 32'h0F0F_0F0F; t2_y[2] = 32'h0000_0000; t2_z[2] = 1'b1;
    t2_op[3] = 2'b11; t2_a[3] = 32'h00FF_0000; t2_b[3] = 32'h0000_FF00; t2_y[3] = 32'h00FF_FF00; t2_z[3] = 1'b0;

    // 1: reset state, then a single add from requester 0
    set_req(0, 2'b00, 32'd5, 32'd3);
    req_valid = 4'b0001;
    cycle();
    cycle();
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_y",     resp_y,              32'd0);
    check("rst_zero",  {31'd0, resp_zero},  32'd0);
    check("rst_id",    {30'd0, resp_id},    32'd0);
    check("rst_ready", {28'd0, req_ready},  32'd0);
    rst_n = 1'b1;
    #1;
    check("t1_ready", {28'd0, req_ready}, 32'b0001);
    cycle();
    check_resp("t1", 2'd0, 32'd8, 1'b0);
    req_valid = 4'b0000;

    // 2: back-to-back ops from requester 2
    for (int j = 0; j < 4; j++) begin
      set_req(2, t2_op[j], t2_a[j], t2_b[j]);
      req_valid = 4'b0100;
      #1;
      check("t2_ready", {28'd0, req_ready}, 32'b0100);
      cycle();
      check_resp("t2", 2'd2, t2_y[j], t2_z[j]);
    end
    req_valid = 4'b0000;

    // 3: grant 3 once so the pointer returns to 0, then all four valid
    req_valid = 4'b1000;
    cycle();
    check("t3_pre_id", {30'd0, resp_id}, 32'd3);
    for (int i = 0; i < NREQ; i++) set_req(i, 2'b00, 32'(i), 32'd100);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t3_ready", {28'd0, req_ready}, 32'd1 << (k % 4));
      cycle();
      check_resp("t3", 2'(k % 4), 32'd100 + 32'(k % 4), 1'b0);
    end
    req_valid = 4'b0000;
    cycle();
    check("t3_drain", {31'd0, resp_valid}, 32'd0);

    // 4: grant 1, then 0 and 3 together: 3 wins, then 0
    req_valid = 4'b0010;
    cycle();
    check("t4_id1", {30'd0, resp_id}, 32'd1);
    req_valid = 4'b1001;
    #1;
    check("t4_ready3", {28'd0, req_ready}, 32'b1000);
    cycle();
    check("t4_id3", {30'd0, resp_id}, 32'd3);
    req_valid = 4'b0001;
    #1;
    check("t4_ready0", {28'd0, req_ready}, 32'b0001);
    cycle();
    check_resp("t4_0", 2'd0, 32'd100, 1'b0);

    // 5: stall for 3 cycles, then drain and accept in one cycle
    req_valid  = 4'b1111;
    resp_ready = 1'b0;
    #1;
    check("t5_ready_stall", {28'd0, req_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("t5_ready_hold", {28'd0, req_ready}, 32'd0);
      check_resp("t5_hold", 2'd0, 32'd100, 1'b0);
    end
    resp_ready = 1'b1;
    #1;
    check("t5_ready_go", {28'd0, req_ready}, 32'b0010);
    cycle();
    check_resp("t5_go", 2'd1, 32'd101, 1'b0);

    // 6: asynchronous reset mid-transfer, pointer back to 0
    req_valid = 4'b0110;
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, resp_valid}, 32'd0);
    check("t6_ready", {28'd0, req_ready},  32'd0);
    check("t6_id",    {30'd0, resp_id},    32'd0);
    check("t6_y",     resp_y,              32'd0);
    cycle();
    check("t6_valid_hold", {31'd0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("t6_ready_rel", {28'd0, req_ready}, 32'b0010);
    cycle();
    check_resp("t6_first", 2'd1, 32'd101, 1'b0);
    req_valid = 4'b0000;
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
